// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard event path: scancode prefixes,
// codes the decoder swallows, and the layout of one queued key event.
package kbd_pkg;

    localparam logic [7:0] KBD_PFX_EXT   = 8'hE0;
    localparam logic [7:0] KBD_PFX_REL   = 8'hF0;
    localparam logic [7:0] KBD_PFX_PAUSE = 8'hE1;

    localparam logic [2:0] KBD_PAUSE_LEN = 3'd7;

    // Controller status/acknowledge bytes that never describe a key.
    localparam int         KBD_DROP_N = 6;
    localparam logic [7:0] KBD_DROP_CODES [KBD_DROP_N] =
        '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    localparam int KBD_ENTRY_W  = 10;
    localparam int KBD_REL_BIT  = 9;
    localparam int KBD_EXT_BIT  = 8;
    localparam int KBD_CODE_LSB = 0;

    typedef struct packed {
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } kbd_entry_t;

    function automatic logic kbd_is_drop(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < KBD_DROP_N; i++) begin
            if (b == KBD_DROP_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous show-ahead FIFO: the head entry is held in a register so the
// output is valid from reset and presents the next entry one cycle after a pop.
module kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 10
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          valid,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic          empty, full, do_push, do_pop, drop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rd_nxt  = rd_ptr + AW'(1);
    assign valid   = !empty;

    // NOTE: storage is deliberately left out of reset; only pointers and count define its contents.
    always_ff @(posedge clock) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

    // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rdata    <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_nxt;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;

            if (do_pop) begin
                if (count != ONE_CNT)  rdata <= mem[rd_nxt];
                else if (do_push)      rdata <= wdata;
            end else if (do_push && empty) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/kbd_buffer.sv
// Folds set-2 scancode prefixes (E0/F0/E1 pause) into single key events and
// queues them for the CPU in a show-ahead FIFO.
module kbd_buffer
    import kbd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [7:0]    ps2_data,
    input  logic          ps2_hit,
    input  logic          pop,
    input  logic          clr,
    output logic [7:0]    q_code,
    output logic          q_rel,
    output logic          q_ext,
    output logic          valid,
    output logic [AW:0]   count,
    output logic          overflow
);

    logic       ext_f, rel_f;
    logic [2:0] pause_cnt;
    logic       in_pause, is_prefix, ev_push;
    kbd_entry_t ev;
    logic [KBD_ENTRY_W-1:0] head;

    assign in_pause  = (pause_cnt != 3'd0);
    assign is_prefix = (ps2_data == KBD_PFX_EXT) || (ps2_data == KBD_PFX_REL) ||
                       (ps2_data == KBD_PFX_PAUSE);

    // The pause key's trailing bytes are opaque; only the last one yields an event.
    assign ev_push = ps2_hit && (in_pause ? (pause_cnt == 3'd1)
                                          : !(is_prefix || kbd_is_drop(ps2_data)));

    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    always_comb begin
        ev = '{rel: rel_f, ext: ext_f, code: ps2_data};
        if (in_pause) ev = '{rel: 1'b0, ext: 1'b1, code: KBD_PFX_PAUSE};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ext_f     <= 1'b0;
            rel_f     <= 1'b0;
            pause_cnt <= '0;
        end else if (clr) begin
            ext_f     <= 1'b0;
            rel_f     <= 1'b0;
            pause_cnt <= '0;
        end else if (ps2_hit) begin
            if (in_pause) begin
                pause_cnt <= pause_cnt - 3'd1;
            end else if (ps2_data == KBD_PFX_EXT) begin
                ext_f <= 1'b1;
            end else if (ps2_data == KBD_PFX_REL) begin
                rel_f <= 1'b1;
            end else begin
                if (ps2_data == KBD_PFX_PAUSE) pause_cnt <= KBD_PAUSE_LEN;
                ext_f <= 1'b0;
                rel_f <= 1'b0;
            end
        end
    end

    kbd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (KBD_ENTRY_W)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (ev_push),
        .pop      (pop),
        .clr      (clr),
        .wdata    (ev),
        .rdata    (head),
        .valid    (valid),
        .count    (count),
        .overflow (overflow)
    );

    assign q_code = head[KBD_CODE_LSB +: 8];
    assign q_rel  = head[KBD_REL_BIT];
    assign q_ext  = head[KBD_EXT_BIT];

endmodule

// File: tb/tb_kbd_buffer.sv
// Directed bench for kbd_buffer: a per-cycle vector table for the decoder
// and simple FIFO traffic, then hand-written full/wrap/clear/reset sequences.
module tb_kbd_buffer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] ps2_data = '0;
    logic       ps2_hit = 1'b0;
    logic       pop = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] q_code;
    logic       q_rel, q_ext, valid, overflow;
    logic [4:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    kbd_buffer #(.DEPTH(16), .AW(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ps2_data (ps2_data),
        .ps2_hit  (ps2_hit),
        .pop      (pop),
        .clr      (clr),
        .q_code   (q_code),
        .q_rel    (q_rel),
        .q_ext    (q_ext),
        .valid    (valid),
        .count    (count),
        .overflow (overflow)
    );

    typedef struct {
        logic       hit;
        logic [7:0] data;
        logic       p;
        logic       c;
        logic       exp_valid;
        int         exp_count;
        logic       exp_rel;
        logic       exp_ext;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic hit, input logic [7:0] data, input logic p, input logic c);
        ps2_hit  = hit;
        ps2_data = data;
        pop      = p;
        clr      = c;
        @(posedge clock);
        #1;
        ps2_hit = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic check_head(input string name, input logic rel, input logic ext, input logic [7:0] code);
        check({name, " q_rel"},  32'(q_rel),  32'(rel));
        check({name, " q_ext"},  32'(q_ext),  32'(ext));
        check({name, " q_code"}, 32'(q_code), 32'(code));
    endtask

    function automatic vec_t mk(input logic hit, input logic [7:0] data, input logic p, input logic c,
                                input logic ev, input int ec, input logic er, input logic ee,
                                input logic [7:0] ecode);
        vec_t v;
        v = '{hit, data, p, c, ev, ec, er, ee, ecode};
        return v;
    endfunction

    initial begin
        logic [7:0] model[$];
        logic [7:0] code;

        // Test plan items 1-3 plus repeated prefixes, empty push+pop and clr priority.
        vecs.push_back(mk(1, 8'h1C, 0, 0, 1, 1, 0, 0, 8'h1C));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 1, 1, 0, 0, 8'h1C));
        vecs.push_back(mk(1, 8'h1C, 0, 0, 1, 2, 0, 0, 8'h1C));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 0, 8'h1C));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h75, 0, 0, 1, 1, 0, 1, 8'h75));
        vecs.push_back(mk(1, 8'hFA, 0, 0, 1, 1, 0, 1, 8'h75));
        vecs.push_back(mk(1, 8'hE0, 0, 0, 1, 1, 0, 1, 8'h75));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 1, 1, 0, 1, 8'h75));
        vecs.push_back(mk(1, 8'h75, 0, 0, 1, 2, 0, 1, 8'h75));
        vecs.push_back(mk(1, 8'hAA, 0, 0, 1, 2, 0, 1, 8'h75));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 1, 8'h75));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'hE1, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h14, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h77, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'hE1, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h14, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h77, 0, 0, 1, 1, 0, 1, 8'hE1));
        vecs.push_back(mk(1, 8'h1C, 0, 0, 1, 2, 0, 1, 8'hE1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 0, 8'h1C));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h5A, 0, 0, 1, 1, 1, 1, 8'h5A));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h1C, 1, 0, 1, 1, 0, 0, 8'h1C));
        vecs.push_back(mk(1, 8'h2C, 1, 0, 1, 1, 0, 0, 8'h2C));
        vecs.push_back(mk(1, 8'h3C, 1, 1, 0, 0, 0, 0, 8'h00));

        #2;
        check("reset valid",    32'(valid),    32'd0);
        check("reset count",    32'(count),    32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check_head("reset", 1'b0, 1'b0, 8'h00);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].hit, vecs[i].data, vecs[i].p, vecs[i].c);
            check($sformatf("v%0d valid", i),    32'(valid),    32'(vecs[i].exp_valid));
            check($sformatf("v%0d count", i),    32'(count),    32'(vecs[i].exp_count));
            check($sformatf("v%0d overflow", i), 32'(overflow), 32'd0);
            if (vecs[i].exp_valid)
                check_head($sformatf("v%0d", i), vecs[i].exp_rel, vecs[i].exp_ext, vecs[i].exp_code);
        end

        // Overfill: 17 make codes, the last one must be dropped.
        for (int i = 1; i <= 17; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        check("ovf count",    32'(count),    32'd16);
        check("ovf flag",     32'(overflow), 32'd1);
        check_head("ovf head", 1'b0, 1'b0, 8'h01);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain%0d code", i), 32'(q_code), 32'(i));
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain valid",  32'(valid),    32'd0);
        check("drain sticky", 32'(overflow), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr overflow", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop, wrapping the pointers.
        for (int i = 0; i < 16; i++) begin
            code = 8'h21 + 8'(i);
            model.push_back(code);
            drive(1'b1, code, 1'b0, 1'b0);
        end
        check("full count", 32'(count), 32'd16);
        for (int i = 0; i < 40; i++) begin
            code = 8'h31 + 8'(i);
            drive(1'b1, code, 1'b1, 1'b0);
            void'(model.pop_front());
            model.push_back(code);
            check($sformatf("wrap%0d count", i), 32'(count),    32'd16);
            check($sformatf("wrap%0d ovf", i),   32'(overflow), 32'd0);
            check($sformatf("wrap%0d head", i),  32'(q_code),   32'(model[0]));
        end
        for (int i = 0; i < 16; i++) begin
            code = model.pop_front();
            check($sformatf("tail%0d code", i), 32'(q_code), 32'(code));
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("tail valid", 32'(valid), 32'd0);

        // clr after a pending E0 F0 with 5 entries queued.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
        drive(1'b1, 8'hE0, 1'b0, 1'b0);
        drive(1'b1, 8'hF0, 1'b0, 1'b0);
        check("pre-clr count", 32'(count), 32'd5);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr count",    32'(count),    32'd0);
        check("clr valid",    32'(valid),    32'd0);
        check("clr overflow", 32'(overflow), 32'd0);
        drive(1'b1, 8'h1C, 1'b0, 1'b0);
        check("post-clr count", 32'(count), 32'd1);
        check_head("post-clr", 1'b0, 1'b0, 8'h1C);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // clr in the middle of a pause sequence.
        drive(1'b1, 8'hE1, 1'b0, 1'b0);
        drive(1'b1, 8'h14, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 8'h1C, 1'b0, 1'b0);
        check("pause-clr count", 32'(count), 32'd1);
        check_head("pause-clr", 1'b0, 1'b0, 8'h1C);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset with 5 entries and a pending E0 F0.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
        drive(1'b1, 8'hE0, 1'b0, 1'b0);
        drive(1'b1, 8'hF0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #2;
        check("rst count",    32'(count),    32'd0);
        check("rst valid",    32'(valid),    32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check_head("rst", 1'b0, 1'b0, 8'h00);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        drive(1'b1, 8'h1C, 1'b0, 1'b0);
        check("post-rst count", 32'(count), 32'd1);
        check_head("post-rst", 1'b0, 1'b0, 8'h1C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
